// File: rtl/rv32_pkg.sv
// Shared fetch-path types and RV32 encoding constants.
// No logic; types and constants only.
// Not applicable: holds no flow-controlled state.
package rv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and memory.
// Wires only, zero latency.
// Request side is valid/ready; the response is unconditionally accepted when valid.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    // fetch side issues requests and consumes responses
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // memory side accepts requests and returns data
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC target selection and word-alignment check for the committed instruction.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is committed.
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1v,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jal,
    input  logic        is_jalr,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] jalr_sum;

    assign jalr_sum = rs1v + imm;

    // pick the redirect target; all adds wrap silently at 2^32
    always_comb begin
        target = pc + 32'd4;
        if ((is_branch && branch_taken) || is_jal) begin
            target = pc + imm;
        end else if (is_jalr) begin
            target = jalr_sum & ~32'h1;
        end
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: PC register, request FSM and instruction latch.
// fetch_en to imem request 1 cycle; response to instr_valid 1 cycle (3 cycles minimum end to end).
// Request held stable until imem_req_ready; PC only advances on pc_update once the instruction is held.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    fetch_unit_if.master  imem,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_valid,
    input  logic          pc_update,
    input  logic          branch_taken,
    input  logic          is_branch,
    input  logic          is_jal,
    input  logic          is_jalr,
    input  logic [31:0]   imm,
    input  logic [31:0]   rs1v,
    output logic [31:0]   pc_plus4,
    output logic          misaligned
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic         req_vld;
    logic         rsp_take;
    logic         commit;
    logic [31:0]  tgt_dat;
    logic         tgt_mis;

    next_pc_calc u_next_pc_calc (
        .pc           (pc),
        .imm          (imm),
        .rs1v         (rs1v),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .target       (tgt_dat),
        .misaligned   (tgt_mis)
    );

    // state register; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state plus request/accept/commit strobes; inputs outside their state are ignored
    always_comb begin
        state_nxt = state;
        req_vld   = 1'b0;
        rsp_take  = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fetch_en) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                req_vld = 1'b1;
                if (imem.imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_update) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // address is the PC itself, so it cannot move while the request waits for ready
    assign imem.imem_req_valid = req_vld;
    assign imem.imem_req_addr  = pc;
    assign pc_plus4            = instr_pc + 32'd4;

    // PC, instruction latch and the two single-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSN;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            instr_valid <= rsp_take;
            misaligned  <= commit && tgt_mis;
            if (rsp_take) begin
                instr    <= imem.imem_rsp_data;
                instr_pc <= pc;
            end
            if (commit && !tgt_mis) begin
                pc <= tgt_dat;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of redirect cases, hand sequences, random traffic.
// Runs against a transaction-level PC model.
// Drives and samples on the falling clock edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        pc_update = 1'b0;
    logic        branch_taken = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1v = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        misaligned;

    fetch_unit_if imem_if ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .imem         (imem_if),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .pc_update    (pc_update),
        .branch_taken (branch_taken),
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .imm          (imm),
        .rs1v         (rs1v),
        .pc_plus4     (pc_plus4),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_pc  = 32'h0;

    typedef struct {
        string       name;
        logic        br;
        logic        tk;
        logic        jal;
        logic        jalr;
        logic [31:0] start_pc;
        logic [31:0] imm;
        logic [31:0] rs1v;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference: new PC and misalignment flag from the instruction class rules
    task automatic model_next(input logic br, input logic tk, input logic jal, input logic jalr,
                              input logic [31:0] pc, input logic [31:0] im, input logic [31:0] r1,
                              output logic [31:0] nxt, output logic mis);
        longint unsigned t;
        if (jal || (br && tk)) t = (longint'(pc) + longint'(im)) % 64'h1_0000_0000;
        else if (jalr) begin
            t = (longint'(r1) + longint'(im)) % 64'h1_0000_0000;
            t = t - (t % 2);
        end else t = (longint'(pc) + 4) % 64'h1_0000_0000;
        mis = (t % 4) != 0;
        nxt = mis ? pc : t[31:0];
    endtask

    task automatic do_fetch(input logic [31:0] data, input int stall, input int gap, input bit spur);
        @(negedge clk);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        chk("req_valid", imem_if.imem_req_valid, 1);
        chk("req_addr", imem_if.imem_req_addr, m_pc);
        for (int i = 0; i < stall; i++) begin
            imem_if.imem_req_ready = 1'b0;
            imem_if.imem_rsp_valid = spur;
            imem_if.imem_rsp_data  = ~data;
            @(negedge clk);
            chk("stall_req_valid", imem_if.imem_req_valid, 1);
            chk("stall_req_addr", imem_if.imem_req_addr, m_pc);
        end
        imem_if.imem_req_ready = 1'b1;
        imem_if.imem_rsp_valid = spur;
        imem_if.imem_rsp_data  = ~data;
        @(negedge clk);
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        chk("wait_req_valid", imem_if.imem_req_valid, 0);
        chk("wait_no_valid", instr_valid, 0);
        for (int i = 0; i < gap; i++) @(negedge clk);
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = data;
        @(negedge clk);
        imem_if.imem_rsp_valid = 1'b0;
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, data);
        chk("instr_pc", instr_pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        @(negedge clk);
        chk("instr_valid_pulse", instr_valid, 0);
    endtask

    task automatic do_commit(input logic br, input logic tk, input logic jal, input logic jalr,
                             input logic [31:0] im, input logic [31:0] r1,
                             input logic [31:0] exp_pc, input logic exp_mis);
        @(negedge clk);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        chk("hold_ignores_fetch_en", imem_if.imem_req_valid, 0);
        is_branch = br; branch_taken = tk; is_jal = jal; is_jalr = jalr;
        imm = im; rs1v = r1; pc_update = 1'b1;
        @(negedge clk);
        pc_update = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        is_jal = 1'b0; is_jalr = 1'b0; imm = '0; rs1v = '0;
        chk("misaligned", misaligned, exp_mis);
        m_pc = exp_pc;
        @(negedge clk);
        chk("misaligned_pulse", misaligned, 0);
        chk("idle_req_valid", imem_if.imem_req_valid, 0);
    endtask

    initial begin
        logic [31:0] nx;
        logic        ms;
        int          kind;
        logic [31:0] ri;
        logic [31:0] rr;

        tbl[0] = '{"br_taken",   1, 1, 0, 0, 32'h100,       32'hFFFF_FFF8, 32'h0,   32'hF8,        0};
        tbl[1] = '{"br_not",     1, 0, 0, 0, 32'h100,       32'hFFFF_FFF8, 32'h0,   32'h104,       0};
        tbl[2] = '{"jalr",       0, 0, 0, 1, 32'h40,        32'h2,         32'h203, 32'h204,       0};
        tbl[3] = '{"jal_mis",    0, 0, 1, 0, 32'h100,       32'h6,         32'h0,   32'h100,       1};
        tbl[4] = '{"seq_wrap",   0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,   32'h0,         0};
        tbl[5] = '{"jalr_bit0",  0, 0, 0, 1, 32'h80,        32'h0,         32'h101, 32'h100,       0};
        tbl[6] = '{"jalr_mis",   0, 0, 0, 1, 32'h200,       32'h0,         32'h102, 32'h200,       1};
        tbl[7] = '{"br_wrap",    1, 1, 0, 0, 32'h4,         32'hFFFF_FFF8, 32'h0,   32'hFFFF_FFFC, 0};
        tbl[8] = '{"jal_wrap",   0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20,        32'h0,   32'h10,        0};
        tbl[9] = '{"tk_no_br",   0, 1, 0, 0, 32'h300,       32'h40,        32'h0,   32'h304,       0};

        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = '0;

        // reset state, with a request pending on fetch_en during reset
        rst = 1'b1;
        fetch_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_if.imem_req_valid, 0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        fetch_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_release_no_fetch", imem_if.imem_req_valid, 0);

        // first fetch at minimum latency
        do_fetch(32'h0050_0093, 0, 0, 1'b0);

        // pc_update outside HOLD must be ignored
        do_commit(0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0);
        @(negedge clk);
        is_jal = 1'b1; imm = 32'h40; pc_update = 1'b1;
        @(negedge clk);
        is_jal = 1'b0; imm = '0; pc_update = 1'b0;
        chk("idle_ignores_pc_update", misaligned, 0);

        // long ready stall with spurious responses during REQ
        do_fetch(32'hCAFE_0001, 5, 2, 1'b1);

        // table of redirect cases
        for (int v = 0; v < 10; v++) begin
            do_commit(0, 0, 0, 1, 32'h0, tbl[v].start_pc, tbl[v].start_pc, 0);
            do_fetch($urandom, 0, 0, 1'b0);
            do_commit(tbl[v].br, tbl[v].tk, tbl[v].jal, tbl[v].jalr,
                      tbl[v].imm, tbl[v].rs1v, tbl[v].exp_pc, tbl[v].exp_mis);
            do_fetch($urandom, 0, 0, 1'b0);
            chk({"tbl_", tbl[v].name}, instr_pc, tbl[v].exp_pc);
        end

        // reset while waiting for the response; the late response must be dropped
        do_commit(0, 0, 0, 1, 32'h0, 32'h500, 32'h500, 0);
        @(negedge clk);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        imem_if.imem_req_ready = 1'b1;
        @(negedge clk);
        imem_if.imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'hDEAD_BEEF;
        m_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_instr_valid", instr_valid, 0);
            chk("late_rsp_instr", instr, 32'h0000_0013);
            chk("late_rsp_req_valid", imem_if.imem_req_valid, 0);
        end
        imem_if.imem_rsp_valid = 1'b0;
        do_fetch(32'h1234_5678, 1, 0, 1'b0);

        // random traffic against the PC model
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            ri = $urandom_range(0, 1023) * 4 - 2048;
            if ($urandom_range(0, 3) == 0) ri = ri + $urandom_range(1, 3);
            rr = $urandom;
            if ($urandom_range(0, 1) == 0) rr = rr & ~32'h3;
            model_next(kind <= 1, kind == 0, kind == 2, kind == 3, m_pc, ri, rr, nx, ms);
            do_commit(kind <= 1, (kind == 0) || (kind == 4 && $urandom_range(0, 1) == 1),
                      kind == 2, kind == 3, ri, rr, nx, ms);
            do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 fetch_en  input  1  SHALL be the control-FSM request to start fetching the instruction at the current PC.
REQ-005 imem_req_valid  output  1  SHALL flag a valid instruction-memory read request.
REQ-006 imem_req_addr  output  32  SHALL carry the request address.
REQ-007 imem_req_ready  input  1  SHALL be the memory's acceptance of the request.
REQ-008 imem_rsp_valid  input  1  SHALL qualify the response data.
REQ-009 imem_rsp_data  input  32  SHALL be the fetched instruction word.
REQ-010 instr  output  32  SHALL hold the latched instruction register.
REQ-011 instr_pc  output  32  SHALL hold the PC of the latched instruction.
REQ-012 instr_valid  output  1  SHALL be a one-cycle pulse when instr/instr_pc update.
REQ-013 pc_update  input  1  SHALL be the control-FSM command to commit the next PC.
REQ-014 branch_taken  input  1  SHALL be the registered branch-compare result of the current instruction.
REQ-015 is_branch, is_jal, is_jalr  input  1 each  SHALL classify the current instruction; at most one is set.
REQ-016 imm  input  32  SHALL be the sign-extended immediate; rs1v  input  32  SHALL be the rs1 value.
REQ-017 pc_plus4  output  32  SHALL equal instr_pc + 4 (link value), combinational.
REQ-018 misaligned  output  1  SHALL pulse for one cycle when a committed target is not word-aligned.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE: fetch_en=1 SHALL move to REQ next cycle; otherwise stay in IDLE.
REQ-021 REQ: imem_req_valid SHALL be 1 and imem_req_addr SHALL equal pc, both stable until imem_req_ready=1; on ready, move to WAIT.
REQ-022 WAIT: on imem_rsp_valid=1, instr<=imem_rsp_data, instr_pc<=pc, instr_valid pulses on the following cycle, and the FSM moves to HOLD.
REQ-023 A response is only accepted in WAIT; imem_rsp_valid in the same cycle as the REQ handshake SHALL be ignored.
REQ-024 HOLD: on pc_update=1, pc<=target and the FSM moves to IDLE.
REQ-025 Target SHALL be:
- pc+imm when is_branch&branch_taken or is_jal;
- (rs1v+imm)&~32'h1 when is_jalr;
- otherwise pc+4.
All adds are modulo 2^32, so wrap-around is silent.
REQ-026 If target[1:0]!=2'b00, pc SHALL remain unchanged, misaligned SHALL pulse, and the FSM still moves to IDLE.
REQ-027 fetch_en outside IDLE and pc_update outside HOLD SHALL be ignored.
REQ-028 imem_req_valid SHALL be 0 in every state except REQ.
REQ-029 Minimum latency: fetch_en at cycle N gives req_valid at N+1; with ready at N+1 and rsp at N+2, instr_valid is at N+3.

Reset
REQ-030 On rst, the block SHALL enter IDLE with pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, and instr_valid=misaligned=imem_req_valid=0.
REQ-031 Reset mid-transaction SHALL abandon the request; a late response arriving in IDLE SHALL be discarded.
REQ-032 Reset deassertion SHALL not itself start a fetch.

Structure
REQ-033 Package rv32_pkg SHALL hold:
- the fetch_state_t enum;
- opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111);
- NOP_INSN.
REQ-034 Sub-module next_pc_calc (combinational target and misalignment logic) SHALL be instantiated once; registers and FSM stay in fetch_unit.

Verification
REQ-035 Reset, fetch_en, ready=1, rsp=32'h00500093 -> imem_req_addr=0, instr=32'h00500093, instr_pc=0, instr_valid pulses once.
REQ-036 HOLD, is_branch=1, branch_taken=1, imm=-8, pc=32'h100, pc_update -> next imem_req_addr=32'hF8; with branch_taken=0 -> 32'h104.
REQ-037 is_jalr=1, rs1v=32'h203, imm=2, pc_update -> pc=32'h204; is_jal=1, imm=6 -> misaligned pulses and pc is unchanged.
REQ-038 imem_req_ready held low 5 cycles -> req_valid and addr stable throughout; a spurious rsp_valid during REQ is ignored.
REQ-039 rst asserted in WAIT, then rsp_valid arrives -> state IDLE, instr=NOP, instr_valid=0.
REQ-040 pc=32'hFFFF_FFFC, sequential pc_update -> pc wraps to 32'h0000_0000.
